if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register.
- Owns the PC and drives the instruction-memory (I-cache) request, holding it stable across cache stalls.
- Absorbs branch/jump redirects from EX, including redirects that arrive while a miss is in flight.
- Registers instruction and PC into ID, and pre-decodes the opcode into the 3-bit immediate-type code consumed by the ID-stage immediate generator (id_instr[31:7] and id_type feed it directly).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, PC/instruction width; only 32 is supported.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_ren  out  1  fetch request valid.
- imem_addr  out  32  fetch byte address (= PC, word aligned).
- imem_rdata  in  32  instruction; valid in the same cycle imem_ren=1 and imem_stall=0.
- imem_stall  in  1  memory busy; request must be held unchanged while high.
- redirect_valid  in  1  taken branch/jump from EX; flush and refetch.
- redirect_pc  in  32  redirect target.
- id_stall  in  1  ID hazard hold (e.g. load-use); freeze PC and IF/ID.
- id_valid  out  1  IF/ID register holds a live instruction.
- id_instr  out  32  registered instruction.
- id_pc  out  32  PC of id_instr.
- id_type  out  3  immediate-type code of id_instr.
- id_illegal  out  1  unrecognised opcode (see Optional Feature).

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=FETCH, pend_pc=0; id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=0, id_type=3'b001, id_illegal=0. Reset overrides everything, including a pending miss; the stale response is not tracked.
- imem_ren=1 whenever rst=0. imem_addr=pc in FETCH/WAIT, old held pc in DROP.
- States:
  - FETCH: issue at pc.
    - imem_stall=1 -> WAIT; in the same cycle, redirect_valid=1 -> DROP with pend_pc=redirect_pc.
    - imem_stall=0: see priority rules below.
  - WAIT: hold pc/address.
    - redirect_valid=1 -> DROP, pend_pc=redirect_pc, id_valid<=0.
    - imem_stall=0 -> handled as FETCH completion, same rules.
  - DROP: hold old address until imem_stall=0; data discarded, id_valid<=0.
    - On completion: pc<=pend_pc, ->FETCH.
    - A later redirect in DROP overwrites pend_pc.
- Priority on a completed fetch (imem_stall=0):
  - redirect_valid: pc<=redirect_pc, id_valid<=0, discard data (flush wins over id_stall).
  - else id_stall: pc and IF/ID hold; the same address is refetched next cycle.
  - else: IF/ID<=(imem_rdata, pc, type, 1), pc<=pc+4.
- id_stall while the stage is not completing: IF/ID holds.
- PC arithmetic is mod 2^32; 32'hFFFF_FFFC+4 wraps to 0. redirect_pc[1:0] is forced to 0.
- Latency: 1 cycle from data return to id_valid. Steady state is 1 instruction/cycle with no stalls.
- Type decode on opcode[6:0]:
  - 0110011 -> 000 R
  - 0010011 -> 001 I
  - 0100011 -> 010 S
  - 1100011 -> 011 B
  - 0110111/0010111 -> 100 U
  - 1101111 -> 101 J
  - 0000011 -> 110 load-I
  - 1100111 -> 111 JALR-I
  - other -> 000, illegal.
- Flushed slots: id_valid=0. id_instr/id_pc/id_type keep their last values; ID qualifies on id_valid.

Optional Feature:
- Macro IF_ILLEGAL_DETECT_EN.
- Defined: id_illegal registers with the IF/ID load, 1 when the opcode is unrecognised or instr[1:0]!=2'b11. It is cleared on flush.
- Undefined: id_illegal is tied to 0 and no detection logic is built; id_type for unknown opcodes is still 000.

Test Plan:
- Reset then 4 fetches, no stalls, RESET_PC=0: imem_addr 0,4,8,C on consecutive cycles. id_pc follows one cycle later with id_valid=1. 32'h00500093 -> id_type=001; 32'h00112023 -> 010; 32'hFE000EE3 -> 011.
- imem_stall high 3 cycles at pc=8: imem_addr=8 held all 3 cycles. id_valid=0 during the miss; one cycle after stall drops, id_pc=8 and id_valid=1.
- redirect_valid with redirect_pc=0x100 while imem_stall=1 at pc=0x10: address stays 0x10 until stall drops. Data is discarded (id_valid=0), then imem_addr=0x100.
- redirect_valid and id_stall in the same cycle, redirect_pc=0x40: id_valid=0 next cycle; next address 0x40.
- id_stall 2 cycles: id_instr/id_pc unchanged and imem_addr repeats. Opcode 1111111 with macro defined -> id_illegal=1, id_type=000.
- rst asserted mid-miss (state WAIT): next cycle pc=RESET_PC, id_valid=0, state FETCH. PC wrap: pc=FFFF_FFFC completes -> next imem_addr=0.

Source files
------------

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID register and immediate-type pre-decode
// Optional IF_ILLEGAL_DETECT_EN: registers id_illegal for unknown opcodes or instr[1:0]!=2'b11.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_ren,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_stall,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [2:0]      id_type,
    output logic            id_illegal
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DROP} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_instr_q, id_instr_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [2:0]      id_type_q, id_type_d;
    logic            flush;
    logic            load;
    logic [XLEN-1:0] redir_pc;

    function automatic logic [2:0] imm_type(input logic [6:0] op);
        case (op)
            7'b0110011: imm_type = 3'b000;
            7'b0010011: imm_type = 3'b001;
            7'b0100011: imm_type = 3'b010;
            7'b1100011: imm_type = 3'b011;
            7'b0110111,
            7'b0010111: imm_type = 3'b100;
            7'b1101111: imm_type = 3'b101;
            7'b0000011: imm_type = 3'b110;
            7'b1100111: imm_type = 3'b111;
            default:    imm_type = 3'b000;
        endcase
    endfunction

    assign redir_pc  = {redirect_pc[XLEN-1:2], 2'b00};
    assign imem_ren  = ~rst;
    // pc only moves on completion, so in DROP it still holds the abandoned address
    assign imem_addr = pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        id_type_d  = id_type_q;
        flush      = 1'b0;
        load       = 1'b0;
        case (state_q)
            S_FETCH, S_WAIT: begin
                if (imem_stall) begin
                    if (redirect_valid) begin
                        state_d   = S_DROP;
                        pend_pc_d = redir_pc;
                        flush     = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        if (!id_stall) id_valid_d = 1'b0;
                    end
                end else begin
                    state_d = S_FETCH;
                    if (redirect_valid) begin
                        pc_d  = redir_pc;
                        flush = 1'b1;
                    end else if (!id_stall) begin
                        load = 1'b1;
                        pc_d = pc_q + XLEN'(4);
                    end
                end
            end
            default: begin
                flush = 1'b1;
                if (redirect_valid) pend_pc_d = redir_pc;
                if (!imem_stall) begin
                    state_d = S_FETCH;
                    pc_d    = redirect_valid ? redir_pc : pend_pc_q;
                end
            end
        endcase
        if (flush) id_valid_d = 1'b0;
        if (load) begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata;
            id_pc_d    = pc_q;
            id_type_d  = imm_type(imem_rdata[6:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            pend_pc_q  <= '0;
            id_valid_q <= 1'b0;
            id_instr_q <= 32'h0000_0013;
            id_pc_q    <= '0;
            id_type_q  <= 3'b001;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_type_q  <= id_type_d;
        end
    end

`ifdef IF_ILLEGAL_DETECT_EN
    logic id_illegal_q, id_illegal_d;

    function automatic logic known_op(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b0000011,
            7'b1100111: known_op = 1'b1;
            default:    known_op = 1'b0;
        endcase
    endfunction

    always_comb begin
        id_illegal_d = id_illegal_q;
        if (flush) id_illegal_d = 1'b0;
        if (load)  id_illegal_d = !known_op(imem_rdata[6:0]) || (imem_rdata[1:0] != 2'b11);
    end

    always_ff @(posedge clk) begin
        if (rst) id_illegal_q <= 1'b0;
        else     id_illegal_q <= id_illegal_d;
    end

    assign id_illegal = id_illegal_q;
`else
    assign id_illegal = 1'b0;
`endif

    assign id_valid = id_valid_q;
    assign id_instr = id_instr_q;
    assign id_pc    = id_pc_q;
    assign id_type  = id_type_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed bench for if_stage: fetch, miss, redirect, id_stall, reset, wrap
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [2:0]  id_type;
    logic        id_illegal;

    int nvec = 0;
    int nerr = 0;
    logic exp_ill;

    if_stage #(.RESET_PC(32'h0), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .imem_ren(imem_ren), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_stall(imem_stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_stall(id_stall),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_type(id_type), .id_illegal(id_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        case (a)
            32'h0000_0000: instr_at = 32'h0050_0093;
            32'h0000_0004: instr_at = 32'h0011_2023;
            32'h0000_0008: instr_at = 32'hFE00_0EE3;
            32'h0000_000C: instr_at = 32'h0000_007F;
            32'h0000_0100: instr_at = 32'h0000_2003;
            32'h0000_0040: instr_at = 32'h0000_00E7;
            32'hFFFF_FFFC: instr_at = 32'h0000_0037;
            default:       instr_at = 32'h0000_006F;
        endcase
    endfunction

    assign imem_rdata = instr_at(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef IF_ILLEGAL_DETECT_EN
        exp_ill = 1'b1;
`else
        exp_ill = 1'b0;
`endif
        rst = 1'b1; imem_stall = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; id_stall = 1'b0;
        step;
        chk("rst_ren", {31'b0, imem_ren}, 32'd0);
        chk("rst_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_instr", id_instr, 32'h0000_0013);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_type", {29'b0, id_type}, 32'd1);
        chk("rst_ill", {31'b0, id_illegal}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        rst = 1'b0;
        #1 chk("ren", {31'b0, imem_ren}, 32'd1);

        // straight-line fetch
        step;
        chk("f0_addr", imem_addr, 32'h4);
        chk("f0_pc", id_pc, 32'h0);
        chk("f0_valid", {31'b0, id_valid}, 32'd1);
        chk("f0_type", {29'b0, id_type}, 32'd1);
        step;
        chk("f1_addr", imem_addr, 32'h8);
        chk("f1_pc", id_pc, 32'h4);
        chk("f1_type", {29'b0, id_type}, 32'd2);

        // three-cycle miss at pc=8
        imem_stall = 1'b1;
        step;
        chk("m1_addr", imem_addr, 32'h8);
        chk("m1_valid", {31'b0, id_valid}, 32'd0);
        step;
        chk("m2_addr", imem_addr, 32'h8);
        chk("m2_valid", {31'b0, id_valid}, 32'd0);
        imem_stall = 1'b0;
        step;
        chk("m3_pc", id_pc, 32'h8);
        chk("m3_valid", {31'b0, id_valid}, 32'd1);
        chk("m3_type", {29'b0, id_type}, 32'd3);
        chk("m3_instr", id_instr, 32'hFE00_0EE3);
        chk("m3_addr", imem_addr, 32'hC);

        // id_stall for two cycles at pc=C
        id_stall = 1'b1;
        step;
        chk("s1_addr", imem_addr, 32'hC);
        chk("s1_pc", id_pc, 32'h8);
        chk("s1_valid", {31'b0, id_valid}, 32'd1);
        step;
        chk("s2_addr", imem_addr, 32'hC);
        chk("s2_instr", id_instr, 32'hFE00_0EE3);
        id_stall = 1'b0;
        step;
        chk("s3_pc", id_pc, 32'hC);
        chk("s3_type", {29'b0, id_type}, 32'd0);
        chk("s3_ill", {31'b0, id_illegal}, {31'b0, exp_ill});
        chk("s3_addr", imem_addr, 32'h10);

        // redirect during miss at pc=0x10, low bits of target masked
        imem_stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        step;
        chk("d1_addr", imem_addr, 32'h10);
        chk("d1_valid", {31'b0, id_valid}, 32'd0);
        chk("d1_ill", {31'b0, id_illegal}, 32'd0);
        redirect_valid = 1'b0;
        step;
        chk("d2_addr", imem_addr, 32'h10);
        chk("d2_valid", {31'b0, id_valid}, 32'd0);
        imem_stall = 1'b0;
        step;
        chk("d3_addr", imem_addr, 32'h100);
        chk("d3_valid", {31'b0, id_valid}, 32'd0);
        step;
        chk("d4_pc", id_pc, 32'h100);
        chk("d4_type", {29'b0, id_type}, 32'd6);
        chk("d4_addr", imem_addr, 32'h104);

        // redirect beats id_stall
        redirect_valid = 1'b1; redirect_pc = 32'h40; id_stall = 1'b1;
        step;
        chk("r1_valid", {31'b0, id_valid}, 32'd0);
        chk("r1_addr", imem_addr, 32'h40);
        redirect_valid = 1'b0; id_stall = 1'b0;
        step;
        chk("r2_pc", id_pc, 32'h40);
        chk("r2_type", {29'b0, id_type}, 32'd7);
        chk("r2_addr", imem_addr, 32'h44);

        // reset while a miss is outstanding
        imem_stall = 1'b1;
        step;
        chk("w_addr", imem_addr, 32'h44);
        rst = 1'b1;
        step;
        chk("x_addr", imem_addr, 32'h0);
        chk("x_valid", {31'b0, id_valid}, 32'd0);
        chk("x_instr", id_instr, 32'h0000_0013);
        rst = 1'b0; imem_stall = 1'b0;
        step;
        chk("x2_pc", id_pc, 32'h0);
        chk("x2_valid", {31'b0, id_valid}, 32'd1);
        chk("x2_addr", imem_addr, 32'h4);

        // PC wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step;
        chk("z1_addr", imem_addr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        step;
        chk("z2_pc", id_pc, 32'hFFFF_FFFC);
        chk("z2_type", {29'b0, id_type}, 32'd4);
        chk("z2_addr", imem_addr, 32'h0);
        step;
        chk("z3_type", {29'b0, id_type}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
